gmii_frame_arbiter: RTL and testbench

- Frame-level scheduler for the GMII output merge path: shares one GMII egress between NUM_PORTS per-ingress frame FIFOs (AXI-stream read side: valid/ready/data/last).
- Grants one whole frame at a time in round-robin order and enforces the minimum inter-frame gap.
- Aborts and flushes any frame that exceeds the maximum length, keeping egress alive.
- Sits between the clock-domain-crossing input FIFOs and the GMII transmit port, in the egress clock domain.

---
 rtl/gmii_frame_arbiter.sv | 159 +++++++++++++++
 tb/tb_gmii_frame_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_arbiter.sv
`timescale 1ns/1ps
// Round-robin whole-frame arbiter merging NUM_PORTS FIFO read sides onto one GMII egress, with IFG and oversize abort.
// Latency 1 cycle handshake-to-egress; port_ready is decoded from registered grant/state only, never from port_valid.
module gmii_frame_arbiter #(
    parameter int NUM_PORTS        = 3,
    parameter int DATA_W           = 10,
    parameter int IFG_CYCLES       = 12,
    parameter int MAX_FRAME_CYCLES = 1530
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        port_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] port_data,
    input  logic [NUM_PORTS-1:0]        port_last,
    output logic [NUM_PORTS-1:0]        port_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic                        out_er,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [15:0]                 drop_count,
    output logic [15:0]                 underrun_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam int FW = $clog2(MAX_FRAME_CYCLES + 1);

    localparam logic [PW:0]          NP_W       = (PW+1)'(NUM_PORTS);
    localparam logic [PW-1:0]        LAST_PORT  = PW'(NUM_PORTS - 1);
    localparam logic [GW-1:0]        GAP_LAST   = GW'(IFG_CYCLES - 1);
    localparam logic [FW-1:0]        FRAME_LAST = FW'(MAX_FRAME_CYCLES - 1);
    localparam logic [NUM_PORTS-1:0] GRANT_ONE  = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_GAP, ST_ARB, ST_FWD, ST_FLUSH} state_t;

    state_t                 state, state_n;
    logic [GW-1:0]          gap_cnt, gap_n;
    logic [PW-1:0]          rr_ptr, rr_n;
    logic [PW-1:0]          sel, sel_n;
    logic [FW-1:0]          frame_cyc, fcyc_n;
    logic [NUM_PORTS-1:0]   grant_n;
    logic [DATA_W-1:0]      data_n;
    logic                   valid_n, er_n, drop_inc, und_inc;

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [PW-1:0]          arb_off, arb_sel;
    logic [PW:0]            arb_sum;
    logic                   arb_hit;
    logic                   xfer, sel_last;
    logic [DATA_W-1:0]      sel_data;

    assign port_ready = (state == ST_FWD || state == ST_FLUSH) ? grant : '0;
    assign xfer       = |(port_valid & port_ready);
    assign sel_last   = port_last[sel];
    assign sel_data   = port_data[int'(sel)*DATA_W +: DATA_W];

    // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner's offset.
    always_comb begin
        dbl     = {port_valid, port_valid} >> rr_ptr;
        rot     = dbl[NUM_PORTS-1:0];
        arb_hit = |rot;
        arb_off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rot[k]) arb_off = PW'(k);
        end
        arb_sum = {1'b0, rr_ptr} + {1'b0, arb_off};
        arb_sel = (arb_sum >= NP_W) ? PW'(arb_sum - NP_W) : PW'(arb_sum);
    end

    always_comb begin
        state_n  = state;
        gap_n    = gap_cnt;
        rr_n     = rr_ptr;
        sel_n    = sel;
        fcyc_n   = frame_cyc;
        grant_n  = grant;
        data_n   = out_data;
        valid_n  = 1'b0;
        er_n     = 1'b0;
        drop_inc = 1'b0;
        und_inc  = 1'b0;
        case (state)
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_ARB;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            ST_ARB: begin
                if (arb_hit) begin
                    state_n = ST_FWD;
                    grant_n = GRANT_ONE << arb_sel;
                    sel_n   = arb_sel;
                    rr_n    = (arb_sel == LAST_PORT) ? '0 : arb_sel + 1'b1;
                    fcyc_n  = '0;
                end
            end
            ST_FWD: begin
                fcyc_n = frame_cyc + 1'b1;
                // A last word on the timeout cycle still completes the frame normally.
                if (xfer && sel_last) begin
                    data_n  = sel_data;
                    valid_n = 1'b1;
                    state_n = ST_GAP;
                    gap_n   = '0;
                    grant_n = '0;
                end else if (frame_cyc == FRAME_LAST) begin
                    er_n     = 1'b1;
                    drop_inc = 1'b1;
                    state_n  = ST_FLUSH;
                end else if (xfer) begin
                    data_n  = sel_data;
                    valid_n = 1'b1;
                end else begin
                    und_inc = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (xfer && sel_last) begin
                    state_n = ST_GAP;
                    gap_n   = '0;
                    grant_n = '0;
                end
            end
            default: state_n = ST_GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_GAP;
            gap_cnt        <= '0;
            rr_ptr         <= '0;
            sel            <= '0;
            frame_cyc      <= '0;
            grant          <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_er         <= 1'b0;
            drop_count     <= '0;
            underrun_count <= '0;
        end else begin
            state     <= state_n;
            gap_cnt   <= gap_n;
            rr_ptr    <= rr_n;
            sel       <= sel_n;
            frame_cyc <= fcyc_n;
            grant     <= grant_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_er    <= er_n;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (und_inc && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_gmii_frame_arbiter.sv
`timescale 1ns/1ps
// Bench for gmii_frame_arbiter: queue-based FIFO models feed random frames; a frame-level
// round-robin model predicts the egress word stream, idle gaps, aborts and counters.
module tb_gmii_frame_arbiter;
    localparam int NP  = 3;
    localparam int DW  = 10;
    localparam int IFG = 12;
    localparam int MAX = 72;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    port_valid = '0;
    logic [NP*DW-1:0] port_data = '0;
    logic [NP-1:0]    port_last = '0;
    logic [NP-1:0]    port_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_er;
    logic [NP-1:0]    grant;
    logic [15:0]      drop_count;
    logic [15:0]      underrun_count;

    gmii_frame_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .port_valid(port_valid), .port_data(port_data), .port_last(port_last),
        .port_ready(port_ready),
        .out_data(out_data), .out_valid(out_valid), .out_er(out_er),
        .grant(grant), .drop_count(drop_count), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {int data; bit last; int pre;} word_t;
    typedef struct {int data; int gap;} exp_t;

    word_t fq [NP][$];
    int    bub [NP];
    exp_t  exp_q [$];
    int    tests = 0;
    int    fails = 0;
    int    idle = 0;
    int    exp_drop = 0;
    int    exp_und = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit fifo_busy();
        for (int i = 0; i < NP; i++) if (fq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_frame(input int p, input int len, input bit rnd_bub);
        word_t w;
        int total, b;
        total = len;
        for (int k = 0; k < len; k++) begin
            w.data = (p << 8) | int'($urandom_range(0, 255));
            w.last = (k == len - 1);
            w.pre  = 0;
            if (rnd_bub && k > 0 && $urandom_range(0, 7) == 0) begin
                b = int'($urandom_range(1, 4));
                if (total + b <= MAX) begin
                    w.pre = b;
                    total += b;
                end
            end
            fq[p].push_back(w);
        end
    endtask

    // Frame-level model: round-robin over queued frames, each frame either fully
    // forwarded or cut to MAX-1 words plus an error marker when it overruns.
    task automatic build_expected(output int first_p);
        int rr, p, c, s, e, len, bsum, lim, gap_next;
        int pos [NP];
        exp_t x;
        exp_q.delete();
        exp_drop = 0;
        exp_und  = 0;
        rr       = 0;
        first_p  = -1;
        gap_next = -1;
        for (int i = 0; i < NP; i++) pos[i] = 0;
        while (1) begin
            p = -1;
            for (int k = 0; k < NP; k++) begin
                c = (rr + k) % NP;
                if (p < 0 && pos[c] < fq[c].size()) p = c;
            end
            if (p < 0) break;
            if (first_p < 0) first_p = p;
            s = pos[p];
            e = s;
            bsum = 0;
            while (!fq[p][e].last) begin
                e++;
                bsum += fq[p][e].pre;
            end
            len = e - s + 1;
            lim = (len + bsum > MAX) ? s + MAX - 2 : e;
            for (int k = s; k <= lim; k++) begin
                x.data = fq[p][k].data;
                x.gap  = (k == s) ? gap_next : fq[p][k].pre;
                exp_q.push_back(x);
            end
            if (len + bsum > MAX) begin
                x.data = -1;
                x.gap  = 0;
                exp_q.push_back(x);
                exp_drop++;
                gap_next = len - MAX + IFG + 1;
            end else begin
                exp_und += bsum;
                gap_next = IFG + 1;
            end
            pos[p] = e + 1;
            rr = (p + 1) % NP;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            if (fq[i].size() > 0 && bub[i] == 0) begin
                port_valid[i]           = 1'b1;
                port_data[i*DW +: DW]   = DW'(fq[i][0].data);
                port_last[i]            = fq[i][0].last;
            end else begin
                port_valid[i]           = 1'b0;
                port_data[i*DW +: DW]   = '0;
                port_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [NP-1:0] hs;
        exp_t e;
        drive_inputs();
        hs = port_valid & port_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                void'(fq[i].pop_front());
                bub[i] = (fq[i].size() > 0) ? fq[i][0].pre : 0;
            end else if (bub[i] > 0) begin
                bub[i]--;
            end
        end
        check("ready_eq_grant", 32'(port_ready), 32'(grant));
        if (out_valid === 1'b1 || out_er === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("out_without_expected", 32'({out_valid, out_er}), 32'(0));
            end else begin
                e = exp_q.pop_front();
                if (e.data < 0)
                    check("er_pulse", 32'({out_er, out_valid}), 32'(2'b10));
                else
                    check("word", 32'({out_valid, out_er, out_data}), 32'({1'b1, 1'b0, DW'(e.data)}));
                if (e.gap >= 0) check("idle_gap", 32'(idle), 32'(e.gap));
            end
            idle = 0;
        end else begin
            idle++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin
            fq[i].delete();
            bub[i] = 0;
        end
        exp_q.delete();
        drive_inputs();
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_ready", 32'(port_ready), 32'(0));
        check("rst_out", 32'({out_valid, out_er, out_data}), 32'(0));
        check("rst_counters", {drop_count, underrun_count}, 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_arbitrate();
        int fp;
        build_expected(fp);
        idle = 0;
        rst = 1'b1;
        for (int c = 1; c <= IFG + 1; c++) begin
            step();
            if (c == IFG) check("grant_during_gap", 32'(grant), 32'(0));
        end
        check("first_grant", 32'(grant), 32'(1) << fp);
    endtask

    task automatic run_scenario(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || fifo_busy()) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'({exp_q.size() > 0, fifo_busy()}), 32'(0));
        repeat (IFG + 4) step();
        check({name, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
        check({name, "_underrun_count"}, 32'(underrun_count), 32'(exp_und));
    endtask

    initial begin
        int total, n;
        #2;

        // single 64-word frame on port 0
        do_reset();
        add_frame(0, 64, 1'b0);
        release_and_arbitrate();
        run_scenario("single", 3000);

        // two frames per port, strict round-robin with exact gaps
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < NP; p++) add_frame(p, int'($urandom_range(1, 24)), 1'b0);
        release_and_arbitrate();
        run_scenario("round_robin", 3000);

        // three-cycle bubble mid-frame on port 1
        do_reset();
        add_frame(1, 20, 1'b0);
        fq[1][10].pre = 3;
        release_and_arbitrate();
        run_scenario("underrun", 3000);

        // oversize frame on port 2 followed by a normal frame
        do_reset();
        add_frame(2, 100, 1'b0);
        add_frame(2, 10, 1'b0);
        release_and_arbitrate();
        run_scenario("oversize", 3000);

        // last exactly on the timeout cycle, then one word too long
        do_reset();
        add_frame(1, MAX, 1'b0);
        add_frame(1, MAX + 1, 1'b0);
        release_and_arbitrate();
        run_scenario("timeout_edge", 3000);

        // asynchronous reset in the middle of a frame
        do_reset();
        add_frame(0, 40, 1'b0);
        add_frame(1, 5, 1'b0);
        release_and_arbitrate();
        total = exp_q.size();
        n = 0;
        while (exp_q.size() > total - 10 && n < 200) begin
            step();
            n++;
        end
        check("arst_mid_frame_reached", 32'(total - exp_q.size()), 32'(10));
        #1;
        rst = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'(0));
        check("arst_ready", 32'(port_ready), 32'(0));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("arst_hold", 32'({grant, out_valid}), 32'(0));
        exp_q.delete();
        release_and_arbitrate();
        run_scenario("arst_tail", 3000);

        // random frame mix with random bubbles
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < NP; p++) begin
                n = int'($urandom_range(1, 3));
                for (int f = 0; f < n; f++) add_frame(p, int'($urandom_range(1, 40)), 1'b1);
            end
            release_and_arbitrate();
            run_scenario("random", 6000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
